// File: rtl/vec_mem_seq_pkg.sv
// Shared types and sizing for the vector memory-stage sequencer.
package vec_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 16;
  // Lane counter width: enough to index every lane.
  localparam int CNT_W  = $clog2(LANES);

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Pipeline-side request/response and byte-RAM signals of the memory stage.
// The slave modport is the sequencer's view; master is the environment's.
interface vec_mem_seq_if;
  import vec_pkg::*;

  // Pipeline (EX/MEM) side
  logic                MemWriteM;
  logic                MemtoRegM;
  logic [ADDR_W-1:0]   AddrM;
  vec_t                WriteDataM;
  logic                StallM;
  vec_t                ReadDataM;
  logic                ReadValidM;

  // Byte-wide single-port data RAM side
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [LANE_W-1:0]   mem_wd;
  logic [LANE_W-1:0]   mem_rd;

  modport slave (
    input  MemWriteM, MemtoRegM, AddrM, WriteDataM, mem_rd,
    output StallM, ReadDataM, ReadValidM, mem_addr, mem_we, mem_wd
  );

  modport master (
    output MemWriteM, MemtoRegM, AddrM, WriteDataM, mem_rd,
    input  StallM, ReadDataM, ReadValidM, mem_addr, mem_we, mem_wd
  );

endinterface

// File: rtl/vec_mem_seq.sv
// Memory-stage sequencer: splits one 6-lane vector load/store into six
// byte accesses on the data RAM, stalling the pipeline while it runs and
// reassembling load bytes into a vector for writeback.
module vec_mem_seq
  import vec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  vec_mem_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  mem_state_t          state;
  mem_state_t          state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_prev;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic [ADDR_W-1:0]   lane_addr;
  vec_t                wr_data;
  vec_t                rd_data;
  logic                is_load;

  // Lane address wraps modulo 2^ADDR_W by plain truncating addition.
  assign lane_addr = base_addr + {{(ADDR_W-CNT_W){1'b0}}, cnt};
  // Lane whose byte is on mem_rd this cycle (RAM has one cycle of read latency).
  assign cnt_prev  = cnt - 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a store wins over a simultaneous load request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.MemWriteM)      state_next = WRITE;
        else if (bus.MemtoRegM) state_next = READ;
      end
      WRITE:     if (cnt == LAST_LANE) state_next = DONE;
      READ:      if (cnt == LAST_LANE) state_next = READ_WAIT;
      READ_WAIT: state_next = DONE;
      // DONE ignores requests: the finished instruction is still presented.
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Request latches, lane counter, held RAM address and load reassembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      base_addr <= '0;
      addr_hold <= '0;
      wr_data   <= '0;
      rd_data   <= '0;
      is_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MemWriteM) begin
            base_addr <= bus.AddrM;
            wr_data   <= bus.WriteDataM;
            cnt       <= '0;
            is_load   <= 1'b0;
          end else if (bus.MemtoRegM) begin
            base_addr <= bus.AddrM;
            cnt       <= '0;
            is_load   <= 1'b1;
          end
        end
        WRITE: begin
          addr_hold <= lane_addr;
          if (cnt != LAST_LANE) cnt <= cnt + 1'b1;
        end
        READ: begin
          addr_hold <= lane_addr;
          if (cnt != '0) rd_data[cnt_prev] <= bus.mem_rd;
          if (cnt != LAST_LANE) cnt <= cnt + 1'b1;
        end
        READ_WAIT: begin
          rd_data[LANES-1] <= bus.mem_rd;
        end
        default: ;
      endcase
    end
  end

  // Outputs: stall, RAM strobes and the load-complete pulse.
  always_comb begin
    bus.StallM   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = addr_hold;
    case (state)
      IDLE: bus.StallM = bus.MemWriteM | bus.MemtoRegM;
      WRITE: begin
        bus.StallM   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = lane_addr;
      end
      READ: begin
        bus.StallM   = 1'b1;
        bus.mem_addr = lane_addr;
      end
      READ_WAIT: bus.StallM = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_wd     = wr_data[cnt];
  assign bus.ReadDataM  = rd_data;
  assign bus.ReadValidM = (state == DONE) && is_load;

endmodule
